uart_lidar_transmit: RTL and testbench

UART transmitter for the command path to the LiDAR module. It is the TX counterpart of the existing lidar UART receiver. It accepts one command per valid/ready handshake and builds the LiDAR command frame: header 0x5A, LEN, ID, payload, then checksum. It serialises the frame on tx_wire_out as 8N1, LSB first. It sits between the sensor-configuration controller and the TX pin.

---
 rtl/lidar_uart_pkg.sv | 20 ++
 rtl/uart_byte_transmit.sv | 95 +++++++++
 rtl/uart_lidar_transmit.sv | 132 +++++++++++++
 tb/tb_uart_lidar_transmit.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lidar_uart_pkg.sv
// Shared constants and types for the LiDAR UART command path.
package lidar_uart_pkg;

   localparam logic [7:0] LIDAR_HEADER       = 8'h5A;
   localparam logic [7:0] CMD_GET_VERSION    = 8'h01;
   localparam logic [7:0] CMD_SOFT_RESET     = 8'h02;
   localparam logic [7:0] CMD_SET_FRAME_RATE = 8'h03;
   localparam logic [7:0] CMD_SAVE_SETTINGS  = 8'h11;

   // Header, LEN, ID and checksum bytes around the payload.
   localparam int LIDAR_FRAME_OVERHEAD = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_byte_transmit.sv
// Single-byte 8N1 serialiser, LSB first. A new byte may be handed over in the
// last cycle of a stop bit so consecutive bytes leave no idle gap.
module uart_byte_transmit #(
   parameter int BAUD_PERIOD = 868
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       byte_valid_in,
   input  logic [7:0] byte_in,
   output logic       byte_ready_out,
   output logic       tx_out,
   output logic       done_out
);
   import lidar_uart_pkg::*;

   localparam int               CNT_W   = (BAUD_PERIOD > 1) ? $clog2(BAUD_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_PERIOD - 1);

   tx_state_t        state_q, state_d;
   logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       data_q, data_d;
   logic             tx_q, tx_d;
   logic             bit_end;

   assign bit_end        = (baud_cnt_q == CNT_MAX);
   assign done_out       = (state_q == ST_STOP) && bit_end;
   assign byte_ready_out = (state_q == ST_IDLE) || done_out;
   assign tx_out         = tx_q;

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_idx_d  = bit_idx_q;
      data_d     = data_q;
      tx_d       = tx_q;

      if (state_q != ST_IDLE) begin
         baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
      end

      unique case (state_q)
         ST_IDLE: tx_d = 1'b1;
         ST_START: begin
            if (bit_end) begin
               state_d   = ST_DATA;
               bit_idx_d = 3'd0;
               tx_d      = data_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = data_q[bit_idx_d];
               end
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               state_d = ST_IDLE;
               tx_d    = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A handover overrides the return to idle at the end of a stop bit.
      if (byte_valid_in && byte_ready_out) begin
         state_d    = ST_START;
         baud_cnt_d = '0;
         data_d     = byte_in;
         tx_d       = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= 3'd0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         tx_q       <= tx_d;
      end
      data_q <= data_d;
   end

endmodule

// File: rtl/uart_lidar_transmit.sv
// LiDAR command-frame transmitter: sequences header, LEN, ID, payload and a
// running checksum into the byte serialiser.
module uart_lidar_transmit #(
   parameter int INPUT_CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE        = 115200,
   parameter int MAX_PAYLOAD      = 8
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     cmd_valid_in,
   output logic                     cmd_ready_out,
   input  logic [7:0]               cmd_id_in,
   input  logic [3:0]               cmd_len_in,
   input  logic [8*MAX_PAYLOAD-1:0] payload_in,
   output logic                     tx_wire_out,
   output logic                     busy_out,
   output logic                     byte_sent_out,
   output logic                     frame_done_out,
   output logic                     len_err_out,
   output logic [3:0]               byte_counter_out
);
   import lidar_uart_pkg::*;

   localparam int BAUD_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;

   logic                     active_q, active_d;
   logic [3:0]               byte_counter_q, byte_counter_d;
   logic [7:0]               chk_q, chk_d;
   logic [7:0]               id_q, id_d;
   logic [3:0]               len_q, len_d;
   logic [8*MAX_PAYLOAD-1:0] payload_q, payload_d;
   logic                     len_err_q, len_err_d;

   logic       accept, len_bad, last_byte;
   logic       ser_valid, ser_ready, ser_done;
   logic [3:0] next_idx, last_idx, pay_idx;
   logic [7:0] next_byte, ser_byte;

   assign cmd_ready_out = !active_q && ser_ready;
   assign accept        = cmd_valid_in && cmd_ready_out;
   assign len_bad       = (cmd_len_in > 4'(MAX_PAYLOAD));
   assign last_idx      = len_q + 4'(LIDAR_FRAME_OVERHEAD - 1);
   assign last_byte     = (byte_counter_q == last_idx);
   assign next_idx      = byte_counter_q + 4'd1;
   assign pay_idx       = next_idx - 4'd3;

   assign busy_out         = active_q;
   assign byte_sent_out    = active_q && ser_done;
   assign frame_done_out   = byte_sent_out && last_byte;
   assign len_err_out      = len_err_q;
   assign byte_counter_out = byte_counter_q;

   // The byte following the one now finishing is picked in the same cycle its
   // predecessor's stop bit ends, so loading costs no line time.
   always_comb begin
      next_byte = chk_q;
      if (next_idx == 4'd1) begin
         next_byte = {4'd0, len_q} + 8'(LIDAR_FRAME_OVERHEAD);
      end else if (next_idx == 4'd2) begin
         next_byte = id_q;
      end else if (next_idx != last_idx) begin
         for (int k = 0; k < MAX_PAYLOAD; k++) begin
            if (pay_idx == 4'(k)) next_byte = payload_q[8*k +: 8];
         end
      end
   end

   always_comb begin
      active_d       = active_q;
      byte_counter_d = byte_counter_q;
      chk_d          = chk_q;
      id_d           = id_q;
      len_d          = len_q;
      payload_d      = payload_q;
      len_err_d      = 1'b0;
      ser_valid      = 1'b0;
      ser_byte       = next_byte;

      if (accept) begin
         id_d      = cmd_id_in;
         len_d     = cmd_len_in;
         payload_d = payload_in;
         if (len_bad) begin
            len_err_d = 1'b1;
         end else begin
            active_d       = 1'b1;
            byte_counter_d = 4'd0;
            chk_d          = LIDAR_HEADER;
            ser_valid      = 1'b1;
            ser_byte       = LIDAR_HEADER;
         end
      end else if (byte_sent_out) begin
         if (last_byte) begin
            active_d       = 1'b0;
            byte_counter_d = 4'd0;
         end else begin
            byte_counter_d = next_idx;
            ser_valid      = 1'b1;
            if (next_idx != last_idx) chk_d = chk_q + next_byte;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         active_q       <= 1'b0;
         byte_counter_q <= 4'd0;
         len_err_q      <= 1'b0;
      end else begin
         active_q       <= active_d;
         byte_counter_q <= byte_counter_d;
         len_err_q      <= len_err_d;
      end
      chk_q     <= chk_d;
      id_q      <= id_d;
      len_q     <= len_d;
      payload_q <= payload_d;
   end

   uart_byte_transmit #(
      .BAUD_PERIOD(BAUD_PERIOD)
   ) u_byte_tx (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .byte_valid_in (ser_valid),
      .byte_in       (ser_byte),
      .byte_ready_out(ser_ready),
      .tx_out        (tx_wire_out),
      .done_out      (ser_done)
   );

endmodule

// File: tb/tb_uart_lidar_transmit.sv
// Bench for uart_lidar_transmit: per-cycle frame/line model plus a UART line
// decoder and literal frame expectations.
module tb_uart_lidar_transmit;
   import lidar_uart_pkg::*;

   localparam int BP       = 10;
   localparam int MAXP     = 8;
   localparam int BYTE_CYC = 10 * BP;

   typedef logic [7:0] frame_t [16];

   logic        clk = 1'b0;
   logic        rst_in = 1'b0;
   logic        cmd_valid_in = 1'b0;
   logic        cmd_ready_out;
   logic [7:0]  cmd_id_in = 8'h00;
   logic [3:0]  cmd_len_in = 4'd0;
   logic [63:0] payload_in = 64'h0;
   logic        tx_wire_out, busy_out, byte_sent_out, frame_done_out, len_err_out;
   logic [3:0]  byte_counter_out;

   always #5 clk = ~clk;

   uart_lidar_transmit #(
      .INPUT_CLOCK_FREQ(1000),
      .BAUD_RATE       (100),
      .MAX_PAYLOAD     (MAXP)
   ) dut (
      .clk_in          (clk),
      .rst_in          (rst_in),
      .cmd_valid_in    (cmd_valid_in),
      .cmd_ready_out   (cmd_ready_out),
      .cmd_id_in       (cmd_id_in),
      .cmd_len_in      (cmd_len_in),
      .payload_in      (payload_in),
      .tx_wire_out     (tx_wire_out),
      .busy_out        (busy_out),
      .byte_sent_out   (byte_sent_out),
      .frame_done_out  (frame_done_out),
      .len_err_out     (len_err_out),
      .byte_counter_out(byte_counter_out)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         if (fails <= 40)
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic frame_t make_frame(input logic [7:0] id, input int len, input logic [63:0] pl);
      frame_t f;
      int     sum;
      for (int i = 0; i < 16; i++) f[i] = 8'h00;
      f[0] = 8'h5A;
      f[1] = 8'(len + 4);
      f[2] = id;
      for (int k = 0; k < len; k++) f[3 + k] = pl[8*k +: 8];
      sum = 0;
      for (int i = 0; i < len + 3; i++) sum += int'(f[i]);
      f[len + 3] = 8'(sum % 256);
      return f;
   endfunction

   // Reference model: expected outputs follow from the cycle offset since acceptance.
   bit     model_on = 0;
   bit     m_active = 0;
   bit     m_lerr   = 0;
   int     m_start  = 0;
   int     m_n      = 0;
   frame_t m_fb;

   always @(negedge clk) begin
      int   o, byt, bt, ecnt;
      logic etx, ebusy, erdy, esent, edone, lerr_next;
      o = cyc - m_start;
      if (m_active && o < m_n * BYTE_CYC) begin
         byt   = o / BYTE_CYC;
         bt    = (o % BYTE_CYC) / BP;
         etx   = (bt == 0) ? 1'b0 : (bt == 9) ? 1'b1 : m_fb[byt][bt - 1];
         ebusy = 1'b1;
         erdy  = 1'b0;
         ecnt  = byt;
         esent = ((o % BYTE_CYC) == BYTE_CYC - 1);
         edone = (o == m_n * BYTE_CYC - 1);
      end else begin
         etx = 1'b1; ebusy = 1'b0; erdy = 1'b1; ecnt = 0; esent = 1'b0; edone = 1'b0;
      end
      if (model_on) begin
         check("tx_wire_out", int'(tx_wire_out), int'(etx));
         check("busy_out", int'(busy_out), int'(ebusy));
         check("cmd_ready_out", int'(cmd_ready_out), int'(erdy));
         check("byte_counter_out", int'(byte_counter_out), ecnt);
         check("byte_sent_out", int'(byte_sent_out), int'(esent));
         check("frame_done_out", int'(frame_done_out), int'(edone));
         check("len_err_out", int'(len_err_out), int'(m_lerr));
      end
      lerr_next = 1'b0;
      if (!rst_in) begin
         model_on = 1;
         m_active = 0;
      end else if (model_on && cmd_valid_in && erdy) begin
         if (int'(cmd_len_in) > MAXP) begin
            lerr_next = 1'b1;
         end else begin
            m_active = 1;
            m_start  = cyc + 1;
            m_n      = int'(cmd_len_in) + 4;
            m_fb     = make_frame(cmd_id_in, int'(cmd_len_in), payload_in);
         end
      end
      m_lerr = lerr_next;
   end

   // Line decoder and pulse counters.
   bit         mon_on    = 0;
   int         sent_cnt  = 0;
   int         done_cnt  = 0;
   int         lerr_cnt  = 0;
   int         last_done = -1000;
   int         last_gap  = 0;
   logic       prev_tx   = 1'b1;
   logic [7:0] dec_q[$];
   bit         dec_busy  = 0;
   int         dec_s     = 0;
   logic [7:0] dec_b     = 8'h00;

   always @(negedge clk) begin
      int o;
      if (!rst_in) begin
         mon_on   = 1;
         dec_busy = 0;
      end else if (mon_on) begin
         if (byte_sent_out) sent_cnt++;
         if (frame_done_out) begin
            done_cnt++;
            last_done = cyc;
         end
         if (len_err_out) lerr_cnt++;
         if (!tx_wire_out && prev_tx) last_gap = cyc - last_done;
         if (!dec_busy) begin
            if (!tx_wire_out) begin
               dec_busy = 1;
               dec_s    = cyc;
            end
         end else begin
            o = cyc - dec_s;
            if (o % BP == BP / 2 && o / BP >= 1 && o / BP <= 8) dec_b = {tx_wire_out, dec_b[7:1]};
            if (o == 9 * BP + BP / 2) begin
               dec_q.push_back(dec_b);
               dec_busy = 0;
            end
         end
      end
      prev_tx = tx_wire_out;
   end

   task automatic issue(input logic [7:0] id, input logic [3:0] len, input logic [63:0] pl,
                        input bit hold, output int acc_c);
      cmd_id_in    = id;
      cmd_len_in   = len;
      payload_in   = pl;
      cmd_valid_in = 1'b1;
      acc_c        = -1;
      for (int i = 0; i < 3000 && acc_c < 0; i++) begin
         @(negedge clk);
         if (cmd_ready_out && rst_in) acc_c = cyc;
      end
      if (acc_c < 0) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      if (!hold) begin
         cmd_valid_in = 1'b0;
         payload_in   = {$urandom, $urandom};
         cmd_id_in    = 8'($urandom);
         cmd_len_in   = 4'($urandom_range(0, 8));
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy_out || !cmd_ready_out) && n < 3000);
      if (n >= 3000) check("idle_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic check_bytes(input string name, input logic [63:0] exp, input int n, input int from);
      check({name, "_count"}, int'(dec_q.size() - from >= n), 1);
      for (int i = 0; i < n; i++) begin
         if (from + i < dec_q.size())
            check(name, int'(dec_q[from + i]), int'(exp[8*(n - 1 - i) +: 8]));
      end
   endtask

   initial begin : stim
      frame_t     f;
      int         acc, acc2, base_s, base_d, base_l, dq0, len;
      logic [7:0] id;
      logic [63:0] pl;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx", int'(tx_wire_out), 1);
      check("rst_ready", int'(cmd_ready_out), 1);
      check("rst_busy", int'(busy_out), 0);
      check("rst_counter", int'(byte_counter_out), 0);
      @(posedge clk);
      #1 rst_in = 1'b1;

      // Model pins against hand-computed frames.
      f = make_frame(CMD_SAVE_SETTINGS, 0, 64'h0);
      check("pin_save_len", int'(f[1]), 'h04);
      check("pin_save_chk", int'(f[3]), 'h6F);
      f = make_frame(CMD_SET_FRAME_RATE, 2, 64'hFFFF);
      check("pin_wrap_chk", int'(f[5]), 'h61);

      // Save-settings frame.
      base_s = sent_cnt; base_d = done_cnt; dq0 = dec_q.size();
      issue(CMD_SAVE_SETTINGS, 4'd0, 64'h0, 0, acc);
      wait_idle();
      check("save_sent_pulses", sent_cnt - base_s, 4);
      check("save_done_pulses", done_cnt - base_d, 1);
      check("save_done_latency", last_done - acc, 400);
      check_bytes("save_bytes", 64'h5A04116F, 4, dq0);
      check("save_line_idle", int'(tx_wire_out), 1);

      // Set-frame-rate followed back-to-back by get-version.
      dq0 = dec_q.size();
      issue(CMD_SET_FRAME_RATE, 4'd2, 64'h000A, 1, acc);
      issue(CMD_GET_VERSION, 4'd0, 64'h0, 0, acc2);
      @(negedge clk);
      #1;
      check("b2b_start_gap", last_gap, 2);
      check("b2b_ready_after_done", acc2 - last_done, 1);
      wait_idle();
      check_bytes("rate_bytes", 64'h5A06030A006D, 6, dq0);
      check_bytes("b2b_second_bytes", 64'h5A04015F, 4, dq0 + 6);

      // Checksum wrap.
      dq0 = dec_q.size();
      issue(CMD_SET_FRAME_RATE, 4'd2, 64'hFFFF, 0, acc);
      wait_idle();
      check_bytes("wrap_bytes", 64'h5A0603FFFF61, 6, dq0);

      // Length error.
      base_l = lerr_cnt; base_s = sent_cnt;
      issue(CMD_GET_VERSION, 4'd9, 64'h0, 0, acc);
      repeat (5) @(posedge clk);
      #1;
      check("lenerr_pulses", lerr_cnt - base_l, 1);
      check("lenerr_no_bytes", sent_cnt - base_s, 0);
      check("lenerr_ready", int'(cmd_ready_out), 1);

      // Reset during byte 2.
      base_d = done_cnt;
      issue(CMD_SET_FRAME_RATE, 4'd2, 64'h001E, 0, acc);
      repeat (240) @(posedge clk);
      #1 rst_in = 1'b0;
      @(posedge clk);
      #1 rst_in = 1'b1;
      @(negedge clk);
      check("rst_mid_tx", int'(tx_wire_out), 1);
      check("rst_mid_busy", int'(busy_out), 0);
      repeat (600) @(posedge clk);
      #1;
      check("rst_mid_no_done", done_cnt - base_d, 0);
      dq0 = dec_q.size();
      issue(CMD_SET_FRAME_RATE, 4'd2, 64'h001E, 0, acc);
      wait_idle();
      check_bytes("post_rst_bytes", 64'h5A06031E0081, 6, dq0);

      // Randomised commands, including bad lengths and queued requests.
      for (int r = 0; r < 14; r++) begin
         len = $urandom_range(0, 10);
         id  = 8'($urandom);
         pl  = {$urandom, $urandom};
         dq0 = dec_q.size();
         issue(id, 4'(len), pl, 0, acc);
         if ($urandom_range(0, 3) != 0) begin
            wait_idle();
            if (len <= MAXP) begin
               f = make_frame(id, len, pl);
               check("rand_count", int'(dec_q.size() - dq0), len + 4);
               for (int i = 0; i < len + 4 && dq0 + i < dec_q.size(); i++)
                  check("rand_byte", int'(dec_q[dq0 + i]), int'(f[i]));
            end
         end
      end
      wait_idle();
      repeat (5) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
